bin_bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the shift-add-3 (double dabble) method.
- Processes one binary bit per clock and has a start/done handshake.
- Width, digit count and an overflow flag are generalised beyond the 8-bit / 3-digit combinational converter.
- Sits between the frequency counter's binary count register and the 7-segment display driver. The counter pulses `start` on each gate close; the display latches `bcd` on `done`.

---
 rtl/bin_bcd_seq.sv | 149 ++++++++++++++
 tb/tb_bin_bcd_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_seq.sv
// bin_bcd_seq: sequential binary-to-BCD converter using the shift-add-3
// (double dabble) method. It converts one binary bit per clock.
//
// It sits between the frequency counter's binary count register and the
// 7-segment display driver. The counter pulses start when its gate closes,
// and the display latches bcd when done is high.
//
// Parameters
//   BIN_W  : binary operand width (1..32)
//   DIGITS : number of BCD output digits (1..10)
//   CW     : width of the bit counter (derived; do not override)
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, only sampled in IDLE
//   bin      : binary operand, captured on the edge that accepts start
//   busy     : high while in SHIFT or LOAD
//   done     : one-cycle pulse; bcd/overflow are updated in this cycle
//   bcd      : result digits, digit k at [4k+3:4k], digit 0 = ones
//   overflow : value did not fit in DIGITS digits (bcd = value mod 10^DIGITS)
//
// Latency: start accepted at edge E0 -> done high after edge E0+BIN_W+1.
// With start held high, back-to-back conversions repeat every BIN_W+2 cycles.
module bin_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int CW     = $clog2(BIN_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int DW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [BIN_W-1:0]  sr, sr_nx;
  logic [DW-1:0]     dig, dig_nx;
  logic [DW-1:0]     adj;
  logic [DW-1:0]     bcd_nx;
  logic              acc, acc_nx;
  logic              ovf_nx;
  logic              done_nx;
  logic              busy_nx;
  logic [CW-1:0]     cnt, cnt_nx;

  // Digit correction before each shift. A corrected digit of 5..9 becomes
  // 8..12, so the shift moves its top bit into the next digit. Digits are
  // never above 9 here, so the 4-bit add cannot wrap.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = add3(dig[4*k +: 4]);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    dig_nx   = dig;
    acc_nx   = acc;
    cnt_nx   = cnt;
    bcd_nx   = bcd;
    ovf_nx   = overflow;
    done_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sr_nx    = bin;
          dig_nx   = '0;
          acc_nx   = 1'b0;
          cnt_nx   = CW'(BIN_W);
          state_nx = SHIFT;
        end
      end

      SHIFT: begin
        // {digits, sr} shifts left by one. The bit leaving the top digit
        // means the value needs more than DIGITS digits, so it is
        // accumulated as overflow. The lower digits still form the correct
        // value mod 10^DIGITS because lower digits never depend on higher ones.
        dig_nx = {adj[DW-2:0], sr[BIN_W-1]};
        sr_nx  = sr << 1;
        acc_nx = acc | adj[DW-1];
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx = LOAD;
        end
      end

      LOAD: begin
        bcd_nx   = dig;
        ovf_nx   = acc;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase

    // Registered decode of the next state, so busy falls on the same edge
    // that raises done.
    busy_nx = (state_nx != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      dig      <= '0;
      acc      <= 1'b0;
      cnt      <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      dig      <= dig_nx;
      acc      <= acc_nx;
      cnt      <= cnt_nx;
      bcd      <= bcd_nx;
      overflow <= ovf_nx;
      done     <= done_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq. It uses four instances:
//   a : BIN_W=8,  DIGITS=3 (default)
//   b : BIN_W=8,  DIGITS=2 (shares stimulus with a, exercises overflow)
//   c : BIN_W=10, DIGITS=3
//   d : BIN_W=16, DIGITS=5
module tb_bin_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s8 = 1'b0;
  logic [7:0]  b8 = '0;
  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;

  logic        s10 = 1'b0;
  logic [9:0]  b10 = '0;
  logic        busy_c, done_c, ovf_c;
  logic [11:0] bcd_c;

  logic        s16 = 1'b0;
  logic [15:0] b16 = '0;
  logic        busy_d, done_d, ovf_d;
  logic [19:0] bcd_d;

  bin_bcd_seq u_a (
    .clk(clk), .rst_n(rst_n), .start(s8), .bin(b8),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
  );

  bin_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(s8), .bin(b8),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
  );

  bin_bcd_seq #(.BIN_W(10), .DIGITS(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(s10), .bin(b10),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
  );

  bin_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d (
    .clk(clk), .rst_n(rst_n), .start(s16), .bin(b16),
    .busy(busy_d), .done(done_d), .bcd(bcd_d), .overflow(ovf_d)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] e3;
    logic [7:0]  e2;
    logic        o2;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  function automatic logic sel_done(input int w);
    case (w)
      0:       return done_a;
      1:       return done_c;
      default: return done_d;
    endcase
  endfunction

  function automatic logic sel_busy(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_c;
      default: return busy_d;
    endcase
  endfunction

  // Poll, bounded, until done rises. k = cycles since the accepting edge.
  task automatic wait_done(input int w, input string nm, output int k, output int bc);
    k  = 0;
    bc = 0;
    do begin
      cyc();
      k++;
      if (sel_busy(w)) bc++;
    end while (!sel_done(w) && k < 60);
    chk({nm, " done seen"}, 32'(sel_done(w)), 32'd1);
  endtask

  // Start one conversion on instance group w, then scramble bin after acceptance.
  task automatic run(input int w, input logic [15:0] b, input string nm,
                     output int lat, output int bc);
    case (w)
      0:       begin s8  = 1'b1; b8  = b[7:0]; end
      1:       begin s10 = 1'b1; b10 = b[9:0]; end
      default: begin s16 = 1'b1; b16 = b;      end
    endcase
    cyc();
    s8 = 1'b0; s10 = 1'b0; s16 = 1'b0;
    b8 = ~b[7:0]; b10 = ~b[9:0]; b16 = ~b;
    wait_done(w, nm, lat, bc);
    // The accepting-edge sample counts toward the busy total.
    bc = bc + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, t0, td, ndone;

    tv[0] = '{8'd255, 12'h255, 8'h55, 1'b1};
    tv[1] = '{8'd0,   12'h000, 8'h00, 1'b0};
    tv[2] = '{8'd1,   12'h001, 8'h01, 1'b0};
    tv[3] = '{8'd9,   12'h009, 8'h09, 1'b0};
    tv[4] = '{8'd10,  12'h010, 8'h10, 1'b0};
    tv[5] = '{8'd99,  12'h099, 8'h99, 1'b0};
    tv[6] = '{8'd100, 12'h100, 8'h00, 1'b1};
    tv[7] = '{8'd128, 12'h128, 8'h28, 1'b1};
    tv[8] = '{8'd199, 12'h199, 8'h99, 1'b1};
    tv[9] = '{8'd254, 12'h254, 8'h54, 1'b1};

    // Reset state
    cyc(); cyc();
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst bcd",  32'(bcd_a),  32'd0);
    chk("rst ovf",  32'(ovf_a),  32'd0);
    rst_n = 1'b1;
    cyc();

    // Table-driven conversions on the 8-bit instances
    for (int i = 0; i < 10; i++) begin
      run(0, {8'd0, tv[i].b}, $sformatf("vec%0d", i), lat, bc);
      chk($sformatf("vec%0d bcd3", i), 32'(bcd_a), 32'(tv[i].e3));
      chk($sformatf("vec%0d ovf3", i), 32'(ovf_a), 32'd0);
      chk($sformatf("vec%0d bcd2", i), 32'(bcd_b), 32'(tv[i].e2));
      chk($sformatf("vec%0d ovf2", i), 32'(ovf_b), 32'(tv[i].o2));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
      chk($sformatf("vec%0d busy cycles", i), 32'(bc), 32'd9);
      cyc();
      chk($sformatf("vec%0d done pulse", i), 32'(done_a), 32'd0);
      chk($sformatf("vec%0d bcd hold", i), 32'(bcd_a), 32'(tv[i].e3));
    end

    // Back-to-back conversions with start held high through each done
    s8 = 1'b1; b8 = 8'd0;
    cyc();
    t0 = cyc_n;
    wait_done(0, "b2b0", lat, bc);
    chk("b2b0 latency", 32'(cyc_n - t0), 32'd9);
    chk("b2b0 bcd", 32'(bcd_a), 32'h000);
    td = cyc_n;
    b8 = 8'd99;
    wait_done(0, "b2b1", lat, bc);
    chk("b2b1 bcd", 32'(bcd_a), 32'h099);
    chk("b2b1 period", 32'(cyc_n - td), 32'd10);
    td = cyc_n;
    b8 = 8'd100;
    wait_done(0, "b2b2", lat, bc);
    chk("b2b2 bcd", 32'(bcd_a), 32'h100);
    chk("b2b2 ovf2", 32'(ovf_b), 32'd1);
    chk("b2b2 period", 32'(cyc_n - td), 32'd10);
    s8 = 1'b0;
    cyc();
    chk("b2b idle after", 32'(busy_a), 32'd0);

    // start held high while bin toggles during the conversion
    s8 = 1'b1; b8 = 8'd37;
    cyc();
    t0 = cyc_n;
    lat = 0;
    do begin
      b8 = (lat % 2 == 0) ? 8'hC8 : 8'h5A;
      cyc();
      lat++;
    end while (!done_a && lat < 60);
    s8 = 1'b0;
    chk("toggle done seen", 32'(done_a), 32'd1);
    chk("toggle latency", 32'(cyc_n - t0), 32'd9);
    chk("toggle bcd", 32'(bcd_a), 32'h037);
    cyc();
    chk("toggle no restart", 32'(busy_a), 32'd0);

    // Asynchronous reset in the middle of a conversion
    s8 = 1'b1; b8 = 8'd200;
    cyc();
    s8 = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("abort busy before", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy_a), 32'd0);
    chk("abort done", 32'(done_a), 32'd0);
    chk("abort bcd",  32'(bcd_a),  32'd0);
    chk("abort ovf",  32'(ovf_a),  32'd0);
    chk("abort ovf2", 32'(ovf_b),  32'd0);
    cyc();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (done_a || busy_a) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    run(0, 16'd128, "after abort", lat, bc);
    chk("after abort bcd", 32'(bcd_a), 32'h128);
    chk("after abort latency", 32'(lat), 32'd9);

    // BIN_W=10, DIGITS=3
    run(1, 16'd999, "w10 999", lat, bc);
    chk("w10 999 bcd", 32'(bcd_c), 32'h999);
    chk("w10 999 ovf", 32'(ovf_c), 32'd0);
    chk("w10 latency", 32'(lat), 32'd11);
    run(1, 16'd1023, "w10 1023", lat, bc);
    chk("w10 1023 bcd", 32'(bcd_c), 32'h023);
    chk("w10 1023 ovf", 32'(ovf_c), 32'd1);
    run(1, 16'd1000, "w10 1000", lat, bc);
    chk("w10 1000 bcd", 32'(bcd_c), 32'h000);
    chk("w10 1000 ovf", 32'(ovf_c), 32'd1);

    // BIN_W=16, DIGITS=5
    run(2, 16'hFFFF, "w16 ffff", lat, bc);
    chk("w16 ffff bcd", 32'(bcd_d), 32'h65535);
    chk("w16 ffff ovf", 32'(ovf_d), 32'd0);
    chk("w16 latency", 32'(lat), 32'd17);
    chk("w16 busy cycles", 32'(bc), 32'd17);
    run(2, 16'd10000, "w16 10000", lat, bc);
    chk("w16 10000 bcd", 32'(bcd_d), 32'h10000);
    run(2, 16'd4096, "w16 4096", lat, bc);
    chk("w16 4096 bcd", 32'(bcd_d), 32'h04096);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
